shift_add_multiplier: RTL and testbench

Sequential 4x4 unsigned multiplier built around the existing `four_bit_adder`. It is the next stage up in the Lab 1 datapath: the FSM drives the adder's `a`/`b`/`cin` every cycle and consumes its `y`/`cout`, so one adder instance produces an 8-bit product over four cycles. A start/busy/done handshake lets a bench or a later lab controller issue operands and collect results.

---
 rtl/lab1_pkg.sv | 11 +
 rtl/four_bit_adder.sv | 19 +
 rtl/shift_add_multiplier.sv | 78 +++++++
 tb/tb_shift_add_multiplier.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
// Shared constants for the Lab 1 datapath: FSM encoding and multiplier geometry.
package lab1_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int MUL_STEPS = 4;
  localparam int NIBBLE    = 4;

endpackage

// File: rtl/four_bit_adder.sv
// 4-bit ripple adder with carry in/out and a signed-overflow flag.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout,
  output logic       overfl
);

  logic [4:0] sum;

  assign sum    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign y      = sum[3:0];
  assign cout   = sum[4];
  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  assign overfl = (a[3] == b[3]) && (y[3] != a[3]);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier; one shared adder, one step per RUN cycle.
module shift_add_multiplier
  import lab1_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [1:0]          state;
  logic [1:0]          cnt;
  logic [NIBBLE-1:0]   mcand;
  logic [2*NIBBLE-1:0] acc;

  logic [NIBBLE-1:0]   add_a;
  logic [NIBBLE-1:0]   add_b;
  logic [NIBBLE-1:0]   add_y;
  logic                add_cout;
  // Signed overflow carries no meaning for unsigned operands.
  logic                ovf_unused;

  always_comb begin
    add_a = acc[2*NIBBLE-1:NIBBLE];
    add_b = acc[0] ? mcand : '0;
  end

  four_bit_adder u_adder (
    .a      (add_a),
    .b      (add_b),
    .cin    (1'b0),
    .y      (add_y),
    .cout   (add_cout),
    .overfl (ovf_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{NIBBLE{1'b0}}, b};
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Carry lands in acc[7], so the 9-bit sum/shift never truncates.
          acc <= {add_cout, add_y, acc[NIBBLE-1:1]};
          cnt <= cnt + 2'd1;
          if (cnt == 2'(MUL_STEPS - 1)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised and directed bench for shift_add_multiplier against a plain a*b reference.
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_pass   = 0;
  int both_err = 0;

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && busy && done) both_err++;
  end

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int r;
    r = int'(x) * int'(y);
    return 8'(r);
  endfunction

  // Issue one start pulse and observe cycles 1..8 after the accepting edge.
  task automatic do_mul(input logic [3:0] x, input logic [3:0] y,
                        output logic [7:0] p, output int done_at,
                        output int busy_n, output int done_n);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom_range(15, 0));
    b = 4'($urandom_range(15, 0));
    done_at = -1; busy_n = 0; done_n = 0; p = 8'hxx;
    for (int c = 1; c <= 8; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          p = product;
        end
      end
      if (c < 8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    #3;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++;
    if (product !== 8'h00) $display("FAIL reset_product got %h want 00", product); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] p;
    int done_at, busy_n, done_n;
    do_mul(4'd15, 4'd15, p, done_at, busy_n, done_n);
    n_checks++;
    if (p !== ref_mul(4'd15, 4'd15)) $display("FAIL basic_product got %h want %h", p, ref_mul(4'd15, 4'd15)); else n_pass++;
    n_checks++;
    if (done_at !== 5) $display("FAIL basic_latency got %0d want 5", done_at); else n_pass++;
    n_checks++;
    if (busy_n !== 4) $display("FAIL basic_busy_cycles got %0d want 4", busy_n); else n_pass++;
    n_checks++;
    if (done_n !== 1) $display("FAIL basic_done_width got %0d want 1", done_n); else n_pass++;
  endtask

  task automatic test_values();
    logic [3:0] xs [3] = '{4'd13, 4'd1, 4'd0};
    logic [3:0] ys [3] = '{4'd11, 4'd15, 4'd9};
    logic [7:0] p;
    logic [3:0] x, y;
    int done_at, busy_n, done_n;
    for (int i = 0; i < 13; i++) begin
      if (i < 3) begin
        x = xs[i]; y = ys[i];
      end else begin
        x = 4'($urandom_range(15, 0));
        y = 4'($urandom_range(15, 0));
      end
      do_mul(x, y, p, done_at, busy_n, done_n);
      n_checks++;
      if (p !== ref_mul(x, y)) $display("FAIL values_product %0d*%0d got %h want %h", x, y, p, ref_mul(x, y)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n_done, busy_lo;
    logic [7:0] p1, p2;
    int d1, d2;
    n_done = 0; busy_lo = 0; d1 = -1; d2 = -1; p1 = 8'hxx; p2 = 8'hxx;
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      if (!busy) busy_lo++;
      if (done) begin
        n_done++;
        if (n_done == 1) begin d1 = c; p1 = product; end
        if (n_done == 2) begin d2 = c; p2 = product; end
      end
      if (c == 1) begin a = 4'd7; b = 4'd2; end
      if (c == 10) start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (p1 !== ref_mul(4'd3, 4'd5)) $display("FAIL b2b_first got %h want %h", p1, ref_mul(4'd3, 4'd5)); else n_pass++;
    n_checks++;
    if (d1 !== 5) $display("FAIL b2b_first_cycle got %0d want 5", d1); else n_pass++;
    n_checks++;
    if (p2 !== ref_mul(4'd7, 4'd2)) $display("FAIL b2b_second got %h want %h", p2, ref_mul(4'd7, 4'd2)); else n_pass++;
    n_checks++;
    if (d2 !== 10) $display("FAIL b2b_second_cycle got %0d want 10", d2); else n_pass++;
    n_checks++;
    if (busy_lo !== 2) $display("FAIL b2b_busy_low got %0d want 2", busy_lo); else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_run_start_ignored();
    int n_done, busy_n, d1;
    logic [7:0] p1, p_late;
    n_done = 0; busy_n = 0; d1 = -1; p1 = 8'hxx; p_late = 8'hxx;
    @(negedge clk);
    a = 4'd6; b = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (busy) busy_n++;
      if (done) begin
        n_done++;
        if (d1 < 0) begin d1 = c; p1 = product; end
      end
      if (c == 9) p_late = product;
      if (c == 2) begin a = 4'd15; b = 4'd15; start = 1'b1; end
      if (c == 3) start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (p1 !== ref_mul(4'd6, 4'd6)) $display("FAIL ignore_product got %h want %h", p1, ref_mul(4'd6, 4'd6)); else n_pass++;
    n_checks++;
    if (d1 !== 5) $display("FAIL ignore_latency got %0d want 5", d1); else n_pass++;
    n_checks++;
    if (n_done !== 1) $display("FAIL ignore_done_count got %0d want 1", n_done); else n_pass++;
    n_checks++;
    if (busy_n !== 4) $display("FAIL ignore_busy_cycles got %0d want 4", busy_n); else n_pass++;
    n_checks++;
    if (p_late !== ref_mul(4'd6, 4'd6)) $display("FAIL ignore_product_hold got %h want %h", p_late, ref_mul(4'd6, 4'd6)); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] p;
    int done_at, busy_n, done_n;
    @(negedge clk);
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL areset_done got %b want 0", done); else n_pass++;
    n_checks++;
    if (product !== 8'h00) $display("FAIL areset_product got %h want 00", product); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(4'd2, 4'd3, p, done_at, busy_n, done_n);
    n_checks++;
    if (p !== ref_mul(4'd2, 4'd3)) $display("FAIL areset_after got %h want %h", p, ref_mul(4'd2, 4'd3)); else n_pass++;
    n_checks++;
    if (done_at !== 5) $display("FAIL areset_latency got %0d want 5", done_at); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [7:0] p;
    logic [3:0] x, y;
    int done_at, busy_n, done_n;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        x = 4'(i); y = 4'(j);
        do_mul(x, y, p, done_at, busy_n, done_n);
        n_checks++;
        if (p !== ref_mul(x, y)) $display("FAIL sweep_product %0d*%0d got %h want %h", x, y, p, ref_mul(x, y)); else n_pass++;
        n_checks++;
        if (done_n !== 1 || done_at !== 5) $display("FAIL sweep_done %0d*%0d got width %0d at %0d want width 1 at 5", x, y, done_n, done_at); else n_pass++;
      end
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_err !== 0) $display("FAIL busy_done_overlap got %0d cycles want 0", both_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_run_start_ignored();
    test_async_reset();
    test_sweep();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
